// File: rtl/policy_cfg_pkg.sv
// Shared definitions for the policy configuration register block:
// address map, CTRL/STATUS bit positions, FSM states and address decode.
package policy_cfg_pkg;

    localparam logic [11:0] APU_BASE    = 12'h000;
    localparam logic [11:0] DPU_BASE    = 12'h400;
    localparam logic [11:0] CTRL_ADDR   = 12'h800;
    localparam logic [11:0] STATUS_ADDR = 12'h804;

    localparam int APU_FIELDS = 4;
    localparam int DPU_FIELDS = 5;
    localparam int APU_F_PERM = 3;

    localparam int CTRL_LOCK    = 0;
    localparam int CTRL_COMMIT  = 1;
    localparam int STAT_LOCKED  = 0;
    localparam int STAT_PENDING = 1;

    typedef enum logic [1:0] {
        IDLE,
        WDATA,
        ERR1,
        ERR2
    } state_t;

    // R_RSV is the unused tail of a DPU entry: reads 0, writes dropped.
    typedef enum logic [2:0] {
        R_APU,
        R_DPU,
        R_RSV,
        R_CTRL,
        R_STATUS,
        R_BAD
    } region_t;

    // Word-granular decode; alignment is checked separately.
    function automatic region_t decode_region(
        input logic [11:0] a,
        input int          n_apu,
        input int          n_dpu
    );
        region_t r;
        r = R_BAD;
        if (a[11:10] == APU_BASE[11:10]) begin
            if (int'(a[9:4]) < n_apu) r = R_APU;
        end else if (a[11:10] == DPU_BASE[11:10]) begin
            if (int'(a[9:5]) < n_dpu)
                r = (int'(a[4:2]) < DPU_FIELDS) ? R_DPU : R_RSV;
        end else if (a[11:2] == CTRL_ADDR[11:2]) begin
            r = R_CTRL;
        end else if (a[11:2] == STATUS_ADDR[11:2]) begin
            r = R_STATUS;
        end
        return r;
    endfunction

endpackage

// File: rtl/policy_cfg_word.sv
// One 32-bit policy field: shadow register written by the bus and an
// active copy loaded from shadow on commit.
// Ports: hclk/hreset, i_we+i_wdata (shadow write), i_commit (shadow->active),
// o_shadow (bus readback), o_active (to the transaction monitor).
module policy_cfg_word
    import policy_cfg_pkg::*;
(
    input  logic        hclk,
    input  logic        hreset,
    input  logic        i_we,
    input  logic        i_commit,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_shadow,
    output logic [31:0] o_active
);

    logic [31:0] r_shadow;
    logic [31:0] r_active;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_shadow <= '0;
            r_active <= '0;
        end else begin
            if (i_we)     r_shadow <= i_wdata;
            if (i_commit) r_active <= r_shadow;
        end
    end

    assign o_shadow = r_shadow;
    assign o_active = r_active;

endmodule

// File: rtl/policy_cfg_regs.sv
// AHB slave holding shadow/active APU and DPU policy tables plus CTRL/STATUS.
// Ports: AHB slave (hclk, hreset, hsel, haddr, htrans, hsize, hwrite, hwdata,
// hready, hmaster, hreadyout, hresp, hrdata); active policy outputs
// apu*/dpu* per entry; cfg_locked.
module policy_cfg_regs
    import policy_cfg_pkg::*;
#(
    parameter int NUM_APU_POLICY = 16,
    parameter int NUM_DPU_POLICY = 16
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic [2:0]  hsize,
    input  logic        hwrite,
    input  logic [31:0] hwdata,
    input  logic        hready,
    input  logic [31:0] hmaster,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata,
    output logic [NUM_APU_POLICY-1:0][31:0] apumid,
    output logic [NUM_APU_POLICY-1:0][31:0] apuaddr,
    output logic [NUM_APU_POLICY-1:0][31:0] apumask,
    output logic [NUM_APU_POLICY-1:0][31:0] apuperm,
    output logic [NUM_DPU_POLICY-1:0][31:0] dpumid,
    output logic [NUM_DPU_POLICY-1:0][31:0] dpuaddr,
    output logic [NUM_DPU_POLICY-1:0][31:0] dpudata,
    output logic [NUM_DPU_POLICY-1:0][31:0] dpumask,
    output logic [NUM_DPU_POLICY-1:0][31:0] dpuamask,
    output logic        cfg_locked
);

    state_t      r_state;
    state_t      w_next;
    region_t     r_reg;
    region_t     w_reg;
    logic [9:2]  r_word;
    logic        r_rd;
    logic        r_locked;
    logic        r_pend;
    logic        w_acc;
    logic        w_err;
    logic        w_wph;
    logic        w_commit;
    logic        w_lock_set;
    logic        w_lock_eff;
    logic        w_shadow_wr;
    logic [31:0] w_rdata;
    logic        w_unused;

    logic [31:0] w_apu_sh  [NUM_APU_POLICY][APU_FIELDS];
    logic [31:0] w_apu_act [NUM_APU_POLICY][APU_FIELDS];
    logic [31:0] w_dpu_sh  [NUM_DPU_POLICY][DPU_FIELDS];
    logic [31:0] w_dpu_act [NUM_DPU_POLICY][DPU_FIELDS];

    assign w_unused = ^{haddr[31:12], hmaster[0], htrans[0]};

    assign w_reg = decode_region(haddr[11:0], NUM_APU_POLICY, NUM_DPU_POLICY);
    // hready is low in ERR1 anyway; the state gate keeps it ignored regardless.
    assign w_acc = hsel & hready & htrans[1] & (r_state != ERR1);
    assign w_wph = (r_state == WDATA);

    assign w_commit   = w_wph & (r_reg == R_CTRL) & hwdata[CTRL_COMMIT];
    assign w_lock_set = w_wph & (r_reg == R_CTRL) & hwdata[CTRL_LOCK];
    // A lock landing this cycle must already block the overlapping address phase.
    assign w_lock_eff = r_locked | w_lock_set;
    assign w_shadow_wr = w_wph & ((r_reg == R_APU) | (r_reg == R_DPU));

    assign w_err = (hsize != 3'b010)
                 | (haddr[1:0] != 2'b00)
                 | (w_reg == R_BAD)
                 | (hwrite & (|hmaster[31:1]))
                 | (hwrite & w_lock_eff & (w_reg != R_STATUS));

    // FSM state register
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // FSM next state
    always_comb begin
        w_next = IDLE;
        case (r_state)
            ERR1: w_next = ERR2;
            default: begin
                if (w_acc) begin
                    if (w_err)       w_next = ERR1;
                    else if (hwrite) w_next = WDATA;
                end
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        hreadyout = (r_state != ERR1);
        hresp     = (r_state == ERR1) | (r_state == ERR2);
        hrdata    = r_rd ? w_rdata : '0;
    end

    // Address phase capture
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_word <= '0;
            r_reg  <= R_BAD;
            r_rd   <= 1'b0;
        end else begin
            r_rd <= w_acc & ~w_err & ~hwrite;
            if (w_acc) begin
                r_word <= haddr[9:2];
                r_reg  <= w_reg;
            end
        end
    end

    // Pending tracks any shadow write since the last commit.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_locked <= 1'b0;
            r_pend   <= 1'b0;
        end else begin
            if (w_lock_set) r_locked <= 1'b1;
            if (w_commit)         r_pend <= 1'b0;
            else if (w_shadow_wr) r_pend <= 1'b1;
        end
    end

    assign cfg_locked = r_locked;

    for (genvar i = 0; i < NUM_APU_POLICY; i++) begin : g_apu
        for (genvar f = 0; f < APU_FIELDS; f++) begin : g_fld
            logic        w_we;
            logic [31:0] w_wd;
            assign w_we = w_wph && (r_reg == R_APU)
                       && (int'(r_word[9:4]) == i)
                       && (int'(r_word[3:2]) == f);
            assign w_wd = (f == APU_F_PERM) ? {30'b0, hwdata[1:0]} : hwdata;
            policy_cfg_word u_word (
                .hclk     (hclk),
                .hreset   (hreset),
                .i_we     (w_we),
                .i_commit (w_commit),
                .i_wdata  (w_wd),
                .o_shadow (w_apu_sh[i][f]),
                .o_active (w_apu_act[i][f])
            );
        end
        assign apumid[i]  = w_apu_act[i][0];
        assign apuaddr[i] = w_apu_act[i][1];
        assign apumask[i] = w_apu_act[i][2];
        assign apuperm[i] = w_apu_act[i][3];
    end

    for (genvar i = 0; i < NUM_DPU_POLICY; i++) begin : g_dpu
        for (genvar f = 0; f < DPU_FIELDS; f++) begin : g_fld
            logic w_we;
            assign w_we = w_wph && (r_reg == R_DPU)
                       && (int'(r_word[9:5]) == i)
                       && (int'(r_word[4:2]) == f);
            policy_cfg_word u_word (
                .hclk     (hclk),
                .hreset   (hreset),
                .i_we     (w_we),
                .i_commit (w_commit),
                .i_wdata  (hwdata),
                .o_shadow (w_dpu_sh[i][f]),
                .o_active (w_dpu_act[i][f])
            );
        end
        assign dpumid[i]   = w_dpu_act[i][0];
        assign dpuaddr[i]  = w_dpu_act[i][1];
        assign dpudata[i]  = w_dpu_act[i][2];
        assign dpumask[i]  = w_dpu_act[i][3];
        assign dpuamask[i] = w_dpu_act[i][4];
    end

    // Readback mux; shadow already holds a word written in the prior data phase.
    always_comb begin
        w_rdata = '0;
        case (r_reg)
            R_APU: begin
                for (int i = 0; i < NUM_APU_POLICY; i++)
                    for (int f = 0; f < APU_FIELDS; f++)
                        if (int'(r_word[9:4]) == i && int'(r_word[3:2]) == f)
                            w_rdata = w_apu_sh[i][f];
            end
            R_DPU: begin
                for (int i = 0; i < NUM_DPU_POLICY; i++)
                    for (int f = 0; f < DPU_FIELDS; f++)
                        if (int'(r_word[9:5]) == i && int'(r_word[4:2]) == f)
                            w_rdata = w_dpu_sh[i][f];
            end
            R_STATUS: begin
                w_rdata[STAT_LOCKED]  = r_locked;
                w_rdata[STAT_PENDING] = r_pend;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_policy_cfg_regs.sv
// Testbench for policy_cfg_regs: directed vector table, hand sequences
// and randomized transfers against a behavioural register-map model.
module tb_policy_cfg_regs;

    localparam int NA = 16;
    localparam int ND = 16;

    logic        hclk = 1'b0;
    logic        hreset, hsel, hwrite, hready;
    logic [31:0] haddr, hwdata, hmaster;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hreadyout, hresp;
    logic [31:0] hrdata;
    logic [NA-1:0][31:0] apumid, apuaddr, apumask, apuperm;
    logic [ND-1:0][31:0] dpumid, dpuaddr, dpudata, dpumask, dpuamask;
    logic        cfg_locked;

    always #5 hclk = ~hclk;

    policy_cfg_regs #(.NUM_APU_POLICY(NA), .NUM_DPU_POLICY(ND)) dut (
        .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr),
        .htrans(htrans), .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata),
        .hready(hready), .hmaster(hmaster), .hreadyout(hreadyout),
        .hresp(hresp), .hrdata(hrdata),
        .apumid(apumid), .apuaddr(apuaddr), .apumask(apumask),
        .apuperm(apuperm), .dpumid(dpumid), .dpuaddr(dpuaddr),
        .dpudata(dpudata), .dpumask(dpumask), .dpuamask(dpuamask),
        .cfg_locked(cfg_locked)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_ash  [NA][4];
    logic [31:0] m_aact [NA][4];
    logic [31:0] m_dsh  [ND][5];
    logic [31:0] m_dact [ND][5];
    bit m_lock, m_pend;

    function automatic void m_reset();
        for (int i = 0; i < NA; i++)
            for (int f = 0; f < 4; f++) begin
                m_ash[i][f] = 0; m_aact[i][f] = 0;
            end
        for (int i = 0; i < ND; i++)
            for (int f = 0; f < 5; f++) begin
                m_dsh[i][f] = 0; m_dact[i][f] = 0;
            end
        m_lock = 0; m_pend = 0;
    endfunction

    function automatic bit m_err(bit wr, logic [31:0] a, logic [2:0] sz,
                                 logic [31:0] m);
        int o;
        bit mapped;
        o = int'(a[11:0]);
        if (o < 'h400)      mapped = (o / 16) < NA;
        else if (o < 'h800) mapped = ((o - 'h400) / 32) < ND;
        else                mapped = (o == 'h800) || (o == 'h804);
        if (sz != 3'd2 || o % 4 != 0 || !mapped) return 1;
        if (wr && m > 1) return 1;
        if (wr && m_lock && o != 'h804) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] m_read(logic [31:0] a);
        int o, f;
        o = int'(a[11:0]);
        if (o < 'h400) return m_ash[o / 16][(o % 16) / 4];
        if (o < 'h800) begin
            f = (o % 32) / 4;
            return (f < 5) ? m_dsh[(o - 'h400) / 32][f] : 32'h0;
        end
        if (o == 'h804) return {30'b0, m_pend, m_lock};
        return 32'h0;
    endfunction

    function automatic void m_write(logic [31:0] a, logic [31:0] d);
        int o, f;
        o = int'(a[11:0]);
        if (o < 'h400) begin
            f = (o % 16) / 4;
            m_ash[o / 16][f] = (f == 3) ? (d & 32'h3) : d;
            m_pend = 1;
        end else if (o < 'h800) begin
            f = (o % 32) / 4;
            if (f < 5) begin
                m_dsh[(o - 'h400) / 32][f] = d;
                m_pend = 1;
            end
        end else if (o == 'h800) begin
            if (d[1]) begin
                m_aact = m_ash;
                m_dact = m_dsh;
                m_pend = 0;
            end
            if (d[0]) m_lock = 1;
        end
    endfunction

    task automatic chk_pol(input string nm);
        int bad;
        logic [31:0] g, w, got;
        bad = -1; g = 0; w = 0;
        for (int i = 0; i < NA; i++)
            for (int f = 0; f < 4; f++) begin
                got = (f == 0) ? apumid[i] : (f == 1) ? apuaddr[i] :
                      (f == 2) ? apumask[i] : apuperm[i];
                if (bad < 0 && got !== m_aact[i][f]) begin
                    bad = i * 8 + f; g = got; w = m_aact[i][f];
                end
            end
        for (int i = 0; i < ND; i++)
            for (int f = 0; f < 5; f++) begin
                got = (f == 0) ? dpumid[i] : (f == 1) ? dpuaddr[i] :
                      (f == 2) ? dpudata[i] : (f == 3) ? dpumask[i] :
                      dpuamask[i];
                if (bad < 0 && got !== m_dact[i][f]) begin
                    bad = 1000 + i * 8 + f; g = got; w = m_dact[i][f];
                end
            end
        n_chk++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s: policy slot %0d got %h expected %h",
                     nm, bad, g, w);
        end
        chk({nm, " locked"}, 32'(cfg_locked), 32'(m_lock));
    endtask

    // One non-pipelined transfer, starting and ending at a negedge.
    task automatic xfer(input bit wr, input logic [31:0] a,
                        input logic [2:0] sz, input logic [31:0] m,
                        input logic [31:0] wd, output bit err,
                        output logic [31:0] rd);
        hsel = 1; htrans = 2'b10; haddr = a; hwrite = wr;
        hsize = sz; hmaster = m; hready = 1;
        @(negedge hclk);
        err = hresp; rd = hrdata;
        hsel = 0; htrans = 2'b00; hwrite = 0; hwdata = wd;
        if (err) begin
            chk("err1 hreadyout", 32'(hreadyout), 32'd0);
            chk("err1 hrdata", hrdata, 32'd0);
            hready = 0;
            @(negedge hclk);
            hready = 1;
            chk("err2 ready/resp", {30'b0, hreadyout, hresp}, 32'h3);
            chk("err2 hrdata", hrdata, 32'd0);
        end else begin
            chk("dphase hreadyout", 32'(hreadyout), 32'd1);
        end
        @(negedge hclk);
        chk("idle hresp", 32'(hresp), 32'd0);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [2:0]  sz;
        logic [31:0] m;
        logic [31:0] wd;
        bit          err;
        logic [31:0] rd;
        logic [31:0] mid0;
        logic [31:0] perm0;
    } vec_t;

    function automatic vec_t v(bit wr, logic [31:0] a, logic [2:0] sz,
                               logic [31:0] m, logic [31:0] wd, bit err,
                               logic [31:0] rd, logic [31:0] mid0,
                               logic [31:0] perm0);
        vec_t t;
        t.wr = wr; t.a = a; t.sz = sz; t.m = m; t.wd = wd;
        t.err = err; t.rd = rd; t.mid0 = mid0; t.perm0 = perm0;
        return t;
    endfunction

    vec_t tbl[$];
    bit err;
    logic [31:0] rd;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl.push_back(v(1, 32'h000, 2, 0, 32'h5, 0, 0, 0, 0));
        tbl.push_back(v(1, 32'h00C, 2, 0, 32'h3, 0, 0, 0, 0));
        tbl.push_back(v(0, 32'h000, 2, 0, 0, 0, 32'h5, 0, 0));
        tbl.push_back(v(0, 32'h804, 2, 0, 0, 0, 32'h2, 0, 0));
        tbl.push_back(v(1, 32'h800, 2, 0, 32'h2, 0, 0, 5, 3));
        tbl.push_back(v(0, 32'h804, 2, 0, 0, 0, 32'h0, 5, 3));
        tbl.push_back(v(1, 32'h400, 2, 4, 32'h1, 1, 0, 5, 3));
        tbl.push_back(v(0, 32'h400, 2, 0, 0, 0, 32'h0, 5, 3));
        tbl.push_back(v(1, 32'h004, 0, 0, 32'h77, 1, 0, 5, 3));
        tbl.push_back(v(0, 32'h7FC, 2, 0, 0, 1, 0, 5, 3));
        tbl.push_back(v(1, 32'h00C, 2, 1, 32'hFFFFFFFF, 0, 0, 5, 3));
        tbl.push_back(v(0, 32'h00C, 2, 0, 0, 0, 32'h3, 5, 3));
        tbl.push_back(v(0, 32'h002, 2, 0, 0, 1, 0, 5, 3));
        tbl.push_back(v(0, 32'h808, 2, 0, 0, 1, 0, 5, 3));
        tbl.push_back(v(0, 32'h100, 2, 0, 0, 1, 0, 5, 3));
        tbl.push_back(v(1, 32'h414, 2, 0, 32'hDEAD, 0, 0, 5, 3));
        tbl.push_back(v(0, 32'h414, 2, 0, 0, 0, 32'h0, 5, 3));
        tbl.push_back(v(1, 32'h5F0, 2, 0, 32'h1234, 0, 0, 5, 3));
        tbl.push_back(v(0, 32'h5F0, 2, 0, 0, 0, 32'h1234, 5, 3));
        tbl.push_back(v(0, 32'h600, 2, 0, 0, 1, 0, 5, 3));
        tbl.push_back(v(1, 32'h804, 2, 0, 32'h3, 0, 0, 5, 3));
        tbl.push_back(v(0, 32'h804, 2, 0, 0, 0, 32'h2, 5, 3));
        tbl.push_back(v(0, 32'h800, 2, 0, 0, 0, 32'h0, 5, 3));
        tbl.push_back(v(1, 32'hFFFFF004, 2, 0, 32'hA5A50004, 0, 0, 5, 3));
        tbl.push_back(v(0, 32'h00012004, 2, 0, 0, 0, 32'hA5A50004, 5, 3));

        hreset = 1; hsel = 0; haddr = 0; htrans = 0; hsize = 3'd2;
        hwrite = 0; hwdata = 0; hready = 1; hmaster = 0;
        m_reset();
        repeat (2) @(negedge hclk);
        chk("reset ready/resp", {30'b0, hreadyout, hresp}, 32'h2);
        hreset = 0;
        @(negedge hclk);
        chk("post-reset hrdata", hrdata, 32'd0);
        chk_pol("reset");

        foreach (tbl[k]) begin
            xfer(tbl[k].wr, tbl[k].a, tbl[k].sz, tbl[k].m, tbl[k].wd,
                 err, rd);
            chk($sformatf("vec%0d err", k), 32'(err), 32'(tbl[k].err));
            if (!tbl[k].err && !tbl[k].wr)
                chk($sformatf("vec%0d rdata", k), rd, tbl[k].rd);
            chk($sformatf("vec%0d apumid0", k), apumid[0], tbl[k].mid0);
            chk($sformatf("vec%0d apuperm0", k), apuperm[0], tbl[k].perm0);
            if (!tbl[k].err && tbl[k].wr) m_write(tbl[k].a, tbl[k].wd);
        end
        chk_pol("table");

        // back-to-back write then read of the same word
        hsel = 1; htrans = 2'b10; haddr = 32'h010; hwrite = 1;
        hsize = 3'd2; hmaster = 0;
        @(negedge hclk);
        chk("b2b wr hreadyout", 32'(hreadyout), 32'd1);
        hwdata = 32'hCAFE0010; hwrite = 0;
        @(negedge hclk);
        chk("b2b rd hreadyout", 32'(hreadyout), 32'd1);
        chk("b2b rdata", hrdata, 32'hCAFE0010);
        hsel = 0; htrans = 2'b00;
        m_write(32'h010, 32'hCAFE0010);
        @(negedge hclk);
        chk("b2b after hrdata", hrdata, 32'd0);

        // reset asserted during ERR1
        hsel = 1; htrans = 2'b10; haddr = 32'h808; hwrite = 0;
        @(negedge hclk);
        hsel = 0; htrans = 2'b00; hready = 0;
        chk("pre-reset err1", {30'b0, hreadyout, hresp}, 32'h1);
        #1 hreset = 1;
        #1;
        chk("rst-in-err ready/resp", {30'b0, hreadyout, hresp}, 32'h2);
        chk("rst-in-err hrdata", hrdata, 32'd0);
        m_reset();
        chk_pol("rst-in-err");
        @(negedge hclk);
        hreset = 0; hready = 1;
        @(negedge hclk);
        chk("after reset status", m_read(32'h804), 32'd0);

        // randomized transfers, no locking
        for (int t = 0; t < 300; t++) begin
            bit wr, e_err;
            int sel;
            logic [11:0] lo;
            logic [31:0] a, m, wd, e_rd;
            logic [2:0] sz;
            wr = 1'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 99));
            if (sel < 40)
                lo = 12'($urandom_range(0, 17) * 16 + $urandom_range(0, 3) * 4);
            else if (sel < 75)
                lo = 12'('h400 + $urandom_range(0, 17) * 32
                         + $urandom_range(0, 7) * 4);
            else if (sel < 83) lo = 12'h800;
            else if (sel < 91) lo = 12'h804;
            else if (sel < 96) lo = 12'($urandom) & 12'hFFC;
            else lo = 12'($urandom_range(0, 4095)) | 12'h1;
            a = {20'($urandom), lo};
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
            m = ($urandom_range(0, 6) == 0) ? $urandom
                                            : 32'($urandom_range(0, 1));
            wd = $urandom;
            if (lo == 12'h800) wd = wd & 32'h2;
            e_err = m_err(wr, a, sz, m);
            e_rd = e_err ? 32'h0 : m_read(a);
            xfer(wr, a, sz, m, wd, err, rd);
            chk($sformatf("rand%0d err @%h", t, a), 32'(err), 32'(e_err));
            if (!e_err && !wr)
                chk($sformatf("rand%0d rdata @%h", t, a), rd, e_rd);
            if (!e_err && wr) m_write(a, wd);
            chk_pol($sformatf("rand%0d", t));
        end

        // stage DPU entry 2, commit+lock, then locked behaviour
        xfer(1, 32'h440, 2, 0, 32'hAB, err, rd);
        chk("lock stage err", 32'(err), 32'd0);
        m_write(32'h440, 32'hAB);
        xfer(1, 32'h800, 2, 0, 32'h3, err, rd);
        chk("lock ctrl err", 32'(err), 32'd0);
        m_write(32'h800, 32'h3);
        chk("lock dpumid2", dpumid[2], 32'hAB);
        chk("lock cfg_locked", 32'(cfg_locked), 32'd1);
        xfer(1, 32'h440, 2, 0, 32'h0, err, rd);
        chk("locked shadow wr err", 32'(err), 32'd1);
        xfer(0, 32'h804, 2, 0, 0, err, rd);
        chk("locked status err", 32'(err), 32'd0);
        chk("locked status", rd, 32'h1);
        xfer(1, 32'h800, 2, 0, 32'h2, err, rd);
        chk("locked ctrl wr err", 32'(err), 32'd1);
        xfer(1, 32'h804, 2, 0, 32'h0, err, rd);
        chk("locked status wr err", 32'(err), 32'd0);
        xfer(0, 32'h440, 2, 0, 0, err, rd);
        chk("locked shadow rd", rd, 32'hAB);
        chk_pol("locked");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
